// File: rtl/dr_latch_bank_ctrl.sv
// Synchronous write controller for a shared bank of dual-rail latch words.
// Two requesters are arbitrated round-robin. Each write is sequenced as a
// return-to-zero transfer: null spacer, codeword, close the latch, then drop
// the rails back to null. Completion is taken from the latch read-back rails.
module dr_latch_bank_ctrl #(
   parameter int DW      = 8,
   parameter int DEPTH   = 4,
   parameter int SETTLE  = 1,
   parameter int TIMEOUT = 15,
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_i,
   input  logic [2*AW-1:0]       addr_i,
   input  logic [2*DW-1:0]       data_i,
   output logic [1:0]            ack_o,
   output logic                  err_o,
   output logic                  busy_o,
   output logic [DEPTH-1:0]      lat_o,
   output logic                  cell_rst_o,
   output logic [2*DW-1:0]       rail_o,
   input  logic [2*DEPTH*DW-1:0] rail_i
);

   localparam int                CW             = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]     SETTLE_M1      = CW'(SETTLE - 1);
   localparam logic [CW-1:0]     TIMEOUT_M1     = CW'(TIMEOUT - 1);
   localparam logic [AW:0]       DEPTH_W        = (AW + 1)'(DEPTH);
   localparam logic [DEPTH-1:0]  LAT_ALL_OPAQUE = {DEPTH{1'b1}};
   localparam logic [2*DW-1:0]   RAIL_NULL      = {(2*DW){1'b0}};
   localparam logic [CW-1:0]     CNT_ZERO       = {CW{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_NULL  = 3'd1,
      ST_DATA  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_RTZ   = 3'd4,
      ST_ABORT = 3'd5
   } state_t;

   // Single-rail to dual-rail: 0 -> 01, 1 -> 10. Never produces 11, so an
   // illegal read-back rail pair can never compare equal to a codeword.
   function automatic logic [2*DW-1:0] dr_encode(input logic [DW-1:0] d);
      logic [2*DW-1:0] r;
      r = RAIL_NULL;
      for (int b = 0; b < DW; b++) begin
         r[2*b +: 2] = d[b] ? 2'b10 : 2'b01;
      end
      return r;
   endfunction

   // A word is at the spacer when every rail is low.
   function automatic logic dr_is_null(input logic [2*DW-1:0] r);
      return (r == RAIL_NULL);
   endfunction

   // Addresses at or beyond DEPTH name no latch word.
   function automatic logic addr_in_range(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_W);
   endfunction

   // Latch-enable pattern with only the addressed word transparent (0).
   function automatic logic [DEPTH-1:0] lat_open(input logic [AW-1:0] a);
      logic [DEPTH-1:0] l;
      l = LAT_ALL_OPAQUE;
      for (int w = 0; w < DEPTH; w++) begin
         l[w] = !(addr_in_range(a) && (a == AW'(w)));
      end
      return l;
   endfunction

   state_t            state_r;
   logic [CW-1:0]     cnt_r;
   logic              rr_r;
   logic [1:0]        mask_r;
   logic              win_r;
   logic [AW-1:0]     addr_r;
   logic [DW-1:0]     data_r;
   logic [1:0]        ack_r;
   logic              err_r;
   logic              busy_r;
   logic [DEPTH-1:0]  lat_r;
   logic [2*DW-1:0]   rail_r;
   logic              rst_d_r;
   logic              cell_rst_r;

   logic [2*DW-1:0]   word_s;
   logic [1:0]        req_eff_s;
   logic              grant_s;
   logic              win_s;
   logic [AW-1:0]     win_addr_s;
   logic [DW-1:0]     win_data_s;
   logic              settled_s;
   logic              timeout_s;
   logic              addr_ok_s;
   logic              null_ok_s;
   logic              match_s;

   // Read back the addressed word, mask the just-acked requester, pick a winner
   always_comb begin
      word_s = RAIL_NULL;
      for (int w = 0; w < DEPTH; w++) begin
         word_s = (addr_r == AW'(w)) ? rail_i[w*2*DW +: 2*DW] : word_s;
      end

      req_eff_s = req_i & ~mask_r;
      grant_s   = |req_eff_s;
      if (req_eff_s == 2'b11) begin
         win_s = rr_r;
      end else if (req_eff_s[1]) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
      win_addr_s = win_s ? addr_i[2*AW-1:AW] : addr_i[AW-1:0];
      win_data_s = win_s ? data_i[2*DW-1:DW] : data_i[DW-1:0];

      settled_s = (cnt_r > SETTLE_M1) || (cnt_r == SETTLE_M1);
      timeout_s = (cnt_r == TIMEOUT_M1);
      addr_ok_s = addr_in_range(addr_r);
      null_ok_s = addr_ok_s && dr_is_null(word_s);
      match_s   = addr_ok_s && (word_s == dr_encode(data_r));
   end

   // Write sequencer: state, arbitration and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         rr_r    <= 1'b0;
         mask_r  <= 2'b00;
         win_r   <= 1'b0;
         addr_r  <= {AW{1'b0}};
         data_r  <= {DW{1'b0}};
         ack_r   <= 2'b00;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
         lat_r   <= LAT_ALL_OPAQUE;
         rail_r  <= RAIL_NULL;
      end else begin
         // Pulses default low; the mask follows the ack by exactly one cycle.
         ack_r  <= 2'b00;
         err_r  <= 1'b0;
         mask_r <= ack_r;
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  state_r <= ST_NULL;
                  win_r   <= win_s;
                  addr_r  <= win_addr_s;
                  data_r  <= win_data_s;
                  cnt_r   <= CNT_ZERO;
                  busy_r  <= 1'b1;
                  lat_r   <= lat_open(win_addr_s);
                  rail_r  <= RAIL_NULL;
                  if (req_eff_s == 2'b11) begin
                     rr_r <= ~win_s;
                  end
               end else begin
                  state_r <= ST_IDLE;
                  cnt_r   <= CNT_ZERO;
                  busy_r  <= 1'b0;
                  lat_r   <= LAT_ALL_OPAQUE;
                  rail_r  <= RAIL_NULL;
               end
            end
            ST_NULL: begin
               if (null_ok_s && settled_s) begin
                  state_r <= ST_DATA;
                  cnt_r   <= CNT_ZERO;
                  rail_r  <= dr_encode(data_r);
               end else if (timeout_s) begin
                  state_r <= ST_ABORT;
                  cnt_r   <= CNT_ZERO;
                  lat_r   <= LAT_ALL_OPAQUE;
                  rail_r  <= RAIL_NULL;
                  ack_r   <= win_r ? 2'b10 : 2'b01;
                  err_r   <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            ST_DATA: begin
               if (match_s && settled_s) begin
                  // Close the addressed latch while the codeword is still driven.
                  state_r <= ST_HOLD;
                  cnt_r   <= CNT_ZERO;
                  lat_r   <= LAT_ALL_OPAQUE;
               end else if (timeout_s) begin
                  state_r <= ST_ABORT;
                  cnt_r   <= CNT_ZERO;
                  lat_r   <= LAT_ALL_OPAQUE;
                  rail_r  <= RAIL_NULL;
                  ack_r   <= win_r ? 2'b10 : 2'b01;
                  err_r   <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            ST_HOLD: begin
               state_r <= ST_RTZ;
               cnt_r   <= CNT_ZERO;
               lat_r   <= LAT_ALL_OPAQUE;
               rail_r  <= RAIL_NULL;
               ack_r   <= win_r ? 2'b10 : 2'b01;
            end
            ST_RTZ: begin
               state_r <= ST_IDLE;
               cnt_r   <= CNT_ZERO;
               busy_r  <= 1'b0;
               lat_r   <= LAT_ALL_OPAQUE;
               rail_r  <= RAIL_NULL;
            end
            ST_ABORT: begin
               state_r <= ST_IDLE;
               cnt_r   <= CNT_ZERO;
               busy_r  <= 1'b0;
               lat_r   <= LAT_ALL_OPAQUE;
               rail_r  <= RAIL_NULL;
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= CNT_ZERO;
               busy_r  <= 1'b0;
               lat_r   <= LAT_ALL_OPAQUE;
               rail_r  <= RAIL_NULL;
            end
         endcase
      end
   end

   // Cell reset stretch: asserted during rst and for the first cycle after the
   // controller leaves reset, so the cells clear before any codeword arrives.
   always_ff @(posedge clk) begin
      rst_d_r    <= rst;
      cell_rst_r <= rst | rst_d_r;
   end

   assign ack_o      = ack_r;
   assign err_o      = err_r;
   assign busy_o     = busy_r;
   assign lat_o      = lat_r;
   assign rail_o     = rail_r;
   assign cell_rst_o = cell_rst_r;

endmodule

// File: tb/tb_dr_latch_bank_ctrl.sv
// Self-checking bench for dr_latch_bank_ctrl with a behavioural dual-rail
// latch bank (ideal, slow read-back, or one stuck-illegal word).
module tb_dr_latch_bank_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic                  clk;
   logic                  rst;
   logic [1:0]            req;
   logic [2*AW-1:0]       addr;
   logic [2*DW-1:0]       data;
   logic [1:0]            ack;
   logic                  err;
   logic                  busy;
   logic [DEPTH-1:0]      lat;
   logic                  cell_rst;
   logic [2*DW-1:0]       rail_out;
   logic [2*DEPTH*DW-1:0] rail_in;

   dr_latch_bank_ctrl #(.DW(DW), .DEPTH(DEPTH), .SETTLE(1), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .data_i(data),
      .ack_o(ack), .err_o(err), .busy_o(busy), .lat_o(lat),
      .cell_rst_o(cell_rst), .rail_o(rail_out), .rail_i(rail_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- latch bank model ----------------
   logic [2*DW-1:0] mem [DEPTH];
   logic [2*DW-1:0] d1, d2, d3, src;
   bit              slow_mode;
   int              stuck_word;

   always_comb begin
      logic [2*DW-1:0] v;
      src = slow_mode ? d3 : rail_out;
      for (int w = 0; w < DEPTH; w++) begin
         v = lat[w] ? mem[w] : src;
         if (w == stuck_word && v != 16'h0000) v[1:0] = 2'b11;
         else v = v;
         rail_in[w*2*DW +: 2*DW] = v;
      end
   end

   always @(posedge clk) begin
      d1 <= rail_out;
      d2 <= d1;
      d3 <= d2;
      for (int w = 0; w < DEPTH; w++) begin
         if (cell_rst) mem[w] <= 16'h0000;
         else if (!lat[w]) mem[w] <= src;
      end
   end

   // ---------------- checking ----------------
   int n_pass, n_total, tcount;

   typedef struct { int idx; bit err; int addr; logic [15:0] word; } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  addr;
      logic [7:0]  data;
      int          mode;        // 0 ideal, 1 slow read-back, 2 word 1 stuck
      logic [15:0] exp_rail;
      logic [3:0]  exp_lat;
      int          exp_dcyc;    // cycles in DATA
      int          exp_latency; // drive negedge to ack negedge
      logic        exp_err;
   } vec_t;
   vec_t vecs [5];

   function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
   endfunction

   function automatic logic [15:0] enc(input logic [7:0] d);
      logic [15:0] r;
      for (int b = 0; b < 8; b++) r[2*b +: 2] = d[b] ? 2'b10 : 2'b01;
      return r;
   endfunction

   function automatic void push(int idx, bit e, int a, logic [15:0] w);
      exp_t x;
      x.idx = idx; x.err = e; x.addr = a; x.word = w;
      sb.push_back(x);
   endfunction

   // Advance to the next negedge and score any acknowledge against the queue.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      tcount++;
      if (ack != 2'b00 || err) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 64'({ack, err}), 64'd0);
         end else begin
            e = sb.pop_front();
            check("sb_ack", 64'(ack), 64'(1) << e.idx);
            check("sb_err", 64'(err), 64'(e.err));
            if (!e.err) check("sb_word", 64'(mem[e.addr]), 64'(e.word));
         end
      end
   endtask

   task automatic run_write(input vec_t v);
      int t0, dcyc;
      bit saw_null, done;
      logic [3:0]  lat_ack;
      logic [15:0] rail_ack;
      check("pre_idle_busy", 64'(busy), 64'd0);
      req = v.req;
      if (v.req[1]) begin
         addr = {v.addr, ~v.addr}; data = {v.data, ~v.data};
      end else begin
         addr = {~v.addr, v.addr}; data = {~v.data, v.data};
      end
      slow_mode  = (v.mode == 1);
      stuck_word = (v.mode == 2) ? 1 : -1;
      push(v.req[1] ? 1 : 0, v.exp_err, int'(v.addr), v.exp_rail);
      t0 = tcount; dcyc = 0; saw_null = 0; done = 0;
      lat_ack = 4'h0; rail_ack = 16'hFFFF;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (i == 0) check("busy_in_null", 64'(busy), 64'd1);
         if (lat == v.exp_lat && rail_out == 16'h0000) saw_null = 1;
         if (lat == v.exp_lat && rail_out == v.exp_rail) dcyc++;
         if (ack != 2'b00) begin
            done = 1; lat_ack = lat; rail_ack = rail_out;
         end
      end
      req = 2'b00;
      check("ack_seen", 64'(done), 64'd1);
      check("ack_latency", 64'(tcount - t0), 64'(v.exp_latency));
      check("null_phase_lat", 64'(saw_null), 64'd1);
      check("data_cycles", 64'(dcyc), 64'(v.exp_dcyc));
      check("ack_lat_closed", 64'(lat_ack), 64'hF);
      check("ack_rail_null", 64'(rail_ack), 64'd0);
      tick();
      tick();
      check("post_idle_busy", 64'(busy), 64'd0);
      if (!v.exp_err) check("word_held", 64'(rail_in[int'(v.addr)*16 +: 16]), 64'(v.exp_rail));
      slow_mode = 0; stuck_word = -1;
   endtask

   initial begin
      int t0, n_ack, a0, a1;
      int times [4];
      logic b1, b2, c1, c2;

      vecs[0] = '{req:2'b01, addr:2'd2, data:8'hA5, mode:0, exp_rail:16'h9966,
                  exp_lat:4'b1011, exp_dcyc:1, exp_latency:4, exp_err:1'b0};
      vecs[1] = '{req:2'b10, addr:2'd0, data:8'h00, mode:0, exp_rail:16'h5555,
                  exp_lat:4'b1110, exp_dcyc:1, exp_latency:4, exp_err:1'b0};
      vecs[2] = '{req:2'b01, addr:2'd3, data:8'hFF, mode:0, exp_rail:16'hAAAA,
                  exp_lat:4'b0111, exp_dcyc:1, exp_latency:4, exp_err:1'b0};
      vecs[3] = '{req:2'b10, addr:2'd1, data:8'h3C, mode:1, exp_rail:16'h5AA5,
                  exp_lat:4'b1101, exp_dcyc:4, exp_latency:7, exp_err:1'b0};
      vecs[4] = '{req:2'b01, addr:2'd1, data:8'h81, mode:2, exp_rail:16'h9556,
                  exp_lat:4'b1101, exp_dcyc:15, exp_latency:17, exp_err:1'b1};

      n_pass = 0; n_total = 0; tcount = 0;
      rst = 1'b1; req = 2'b00; addr = '0; data = '0;
      slow_mode = 0; stuck_word = -1;

      // Reset state
      tick(); tick(); tick();
      check("rst_lat", 64'(lat), 64'hF);
      check("rst_rail", 64'(rail_out), 64'd0);
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cell_rst", 64'(cell_rst), 64'd1);
      rst = 1'b0;
      tick();
      check("cell_rst_first", 64'(cell_rst), 64'd1);
      tick();
      check("cell_rst_second", 64'(cell_rst), 64'd0);

      // Table-driven single writes
      for (int i = 0; i < 5; i++) run_write(vecs[i]);

      // Ack masking: same requester keeps requesting, skips one IDLE cycle
      req = 2'b01; addr = 4'h0; data = 16'h000F;
      push(0, 0, 0, enc(8'h0F)); push(0, 0, 0, enc(8'h0F));
      t0 = tcount; n_ack = 0; a0 = 0; a1 = 0; b1 = 1'b1; b2 = 1'b1;
      for (int i = 0; i < 30 && n_ack < 2; i++) begin
         tick();
         if (n_ack == 1 && tcount == a0 + 1) b1 = busy;
         if (n_ack == 1 && tcount == a0 + 2) b2 = busy;
         if (ack != 2'b00) begin
            if (n_ack == 0) a0 = tcount; else a1 = tcount;
            n_ack++;
            if (n_ack == 2) req = 2'b00;
         end
      end
      check("mask_acks", 64'(n_ack), 64'd2);
      check("mask_first_lat", 64'(a0 - t0), 64'd4);
      check("mask_gap", 64'(a1 - a0), 64'd6);
      check("mask_idle1", 64'(b1), 64'd0);
      check("mask_idle2", 64'(b2), 64'd0);
      tick(); tick();

      // Contention from reset with rr = 0
      rst = 1'b1; req = 2'b11; addr = {2'd3, 2'd0}; data = {8'h3C, 8'h96};
      tick(); tick();
      push(0, 0, 0, enc(8'h96)); push(1, 0, 3, enc(8'h3C));
      push(0, 0, 0, enc(8'h96)); push(1, 0, 3, enc(8'h3C));
      rst = 1'b0;
      t0 = tcount; n_ack = 0;
      for (int i = 0; i < 40 && n_ack < 4; i++) begin
         tick();
         if (ack != 2'b00) begin
            times[n_ack] = tcount;
            n_ack++;
            if (n_ack == 4) req = 2'b00;
         end
      end
      check("cont_acks", 64'(n_ack), 64'd4);
      check("cont_first_lat", 64'(times[0] - t0), 64'd4);
      for (int k = 1; k < 4; k++) check("cont_gap", 64'(times[k] - times[k-1]), 64'd5);
      tick(); tick();

      // Reset during DATA: no ack, bank closed, pending requester re-granted
      req = 2'b01; addr = {2'd2, 2'd1}; data = {8'hAA, 8'h55};
      tick(); tick();
      check("midop_in_data", 64'(rail_out), 64'(enc(8'h55)));
      rst = 1'b1;
      tick();
      check("midop_lat", 64'(lat), 64'hF);
      check("midop_rail", 64'(rail_out), 64'd0);
      check("midop_ack", 64'(ack), 64'd0);
      check("midop_err", 64'(err), 64'd0);
      tick();
      rst = 1'b0;
      push(0, 0, 1, enc(8'h55));
      t0 = tcount; n_ack = 0; c1 = 1'b0; c2 = 1'b1;
      for (int i = 0; i < 20 && n_ack < 1; i++) begin
         tick();
         if (i == 0) c1 = cell_rst;
         if (i == 1) c2 = cell_rst;
         if (ack != 2'b00) n_ack++;
      end
      req = 2'b00;
      check("midop_regrant", 64'(n_ack), 64'd1);
      check("midop_lat_after", 64'(tcount - t0), 64'd4);
      check("midop_cell_rst1", 64'(c1), 64'd1);
      check("midop_cell_rst2", 64'(c2), 64'd0);
      tick(); tick();
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
